// File: rtl/pipe_pkg.sv
// pipe_pkg: stall bit indices, stall patterns and multi-cycle sequencer states
package pipe_pkg;
  localparam int STALL_PC  = 0;
  localparam int STALL_IF  = 1;
  localparam int STALL_ID  = 2;
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;
  localparam int STALL_WB  = 5;
  localparam logic [5:0] STALL_NONE    = 6'b000000;
  localparam logic [5:0] STALL_LOADUSE = 6'b000111;
  localparam logic [5:0] STALL_MULTI   = 6'b001111;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} seq_state_e;
endpackage

// File: rtl/pipe_ctrl_ex_multi_seq.sv
// ex_multi_seq: start/done/cancel sequencing of multi-cycle EX ops with watchdog
module ex_multi_seq
  import pipe_pkg::*;
#(
  parameter int MULTI_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic ex_multi_op,
  input  logic multi_done,
  input  logic flush_req,
  output logic busy,
  output logic done,
  output logic multi_start,
  output logic multi_cancel,
  output logic timeout_err
);
  localparam logic [7:0] WD_LAST = 8'(MULTI_TIMEOUT - 1);
  seq_state_e state, state_n;
  logic [7:0] wd, wd_n;
  logic start, cancel, err_set;
  always_comb begin
    state_n = state;
    wd_n = wd;
    start = 1'b0;
    cancel = 1'b0;
    err_set = 1'b0;
    case (state)
      IDLE: if (ex_multi_op && !flush_req) begin
        start = 1'b1;
        state_n = BUSY;
        wd_n = '0;
      end
      BUSY: if (flush_req) begin
        cancel = 1'b1;
        state_n = IDLE;
      end else if (multi_done) begin
        state_n = DONE;
      end else if (wd == WD_LAST) begin
        cancel = 1'b1;
        err_set = 1'b1;
        state_n = DONE;
      end else begin
        wd_n = wd + 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wd <= '0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      wd <= wd_n;
      timeout_err <= timeout_err | err_set;
    end
  end
  // pulses are gated so a reset cycle never starts or aborts the shared unit
  assign multi_start = start && !rst;
  assign multi_cancel = cancel && !rst;
  assign busy = state == BUSY;
  assign done = state == DONE;
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: per-stage stall vector, registered flush/redirect and stall counter
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MULTI_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_stall_req_i,
  input  logic        ex_multi_op_i,
  input  logic        multi_done_i,
  input  logic        flush_req_i,
  input  logic [31:0] flush_pc_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        multi_start_o,
  output logic        multi_cancel_o,
  output logic        timeout_err_o,
  output logic [31:0] stall_cnt_o
);
  logic busy, done;
  ex_multi_seq #(.MULTI_TIMEOUT(MULTI_TIMEOUT)) u_seq (
    .clk(clk),
    .rst(rst),
    .ex_multi_op(ex_multi_op_i),
    .multi_done(multi_done_i),
    .flush_req(flush_req_i),
    .busy(busy),
    .done(done),
    .multi_start(multi_start_o),
    .multi_cancel(multi_cancel_o),
    .timeout_err(timeout_err_o)
  );
  always_comb
    stall_o = (rst || flush_o) ? STALL_NONE :
              (busy || multi_start_o) ? STALL_MULTI :
              (id_stall_req_i && !done) ? STALL_LOADUSE : STALL_NONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_o <= 1'b0;
      new_pc_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      flush_o <= flush_req_i;
      new_pc_o <= flush_pc_i;
      if (stall_o != STALL_NONE && stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed stimulus, per-cycle model comparison plus literal checks
module tb_pipe_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic id_stall_req_i = 1'b0, ex_multi_op_i = 1'b0, multi_done_i = 1'b0, flush_req_i = 1'b0;
  logic [31:0] flush_pc_i = '0;
  logic [5:0] stall_o;
  logic flush_o, multi_start_o, multi_cancel_o, timeout_err_o;
  logic [31:0] new_pc_o, stall_cnt_o;
  int n_cmp = 0, n_bad = 0;

  pipe_ctrl #(.MULTI_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .id_stall_req_i(id_stall_req_i), .ex_multi_op_i(ex_multi_op_i),
    .multi_done_i(multi_done_i), .flush_req_i(flush_req_i), .flush_pc_i(flush_pc_i),
    .stall_o(stall_o), .flush_o(flush_o), .new_pc_o(new_pc_o), .multi_start_o(multi_start_o),
    .multi_cancel_o(multi_cancel_o), .timeout_err_o(timeout_err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model: an operation in flight with its age, a one-cycle completion slot
  bit m_valid = 0, m_busy = 0, m_fin = 0, m_flush = 0, m_err = 0;
  int m_age = 0;
  logic [31:0] m_pc = '0;
  longint m_cnt = 0;

  always @(negedge clk) begin
    bit e_start, e_cancel;
    logic [5:0] e_stall;
    e_start = !rst && !m_busy && !m_fin && ex_multi_op_i && !flush_req_i;
    e_cancel = !rst && m_busy && (flush_req_i || (!multi_done_i && m_age == TO - 1));
    e_stall = (rst || m_flush) ? 6'd0 : (m_busy || e_start) ? 6'b001111 :
              (id_stall_req_i && !m_fin) ? 6'b000111 : 6'd0;
    if (m_valid) begin
      check("stall", 32'(stall_o), 32'(e_stall));
      check("start", 32'(multi_start_o), 32'(e_start));
      check("cancel", 32'(multi_cancel_o), 32'(e_cancel));
      check("flush", 32'(flush_o), 32'(m_flush));
      if (m_flush) check("new_pc", new_pc_o, m_pc);
      check("timeout_err", 32'(timeout_err_o), 32'(m_err));
      check("stall_cnt", stall_cnt_o, (m_cnt > 64'hFFFFFFFF) ? 32'hFFFFFFFF : 32'(m_cnt));
    end
    if (rst) begin
      m_valid = 1; m_busy = 0; m_fin = 0; m_flush = 0; m_err = 0; m_age = 0; m_pc = '0; m_cnt = 0;
    end else begin
      m_flush = flush_req_i;
      m_pc = flush_pc_i;
      if (e_stall != 0) m_cnt++;
      if (m_fin) m_fin = 0;
      else if (!m_busy) begin
        if (e_start) begin m_busy = 1; m_age = 0; end
      end else if (flush_req_i) m_busy = 0;
      else if (multi_done_i) begin m_busy = 0; m_fin = 1; end
      else if (m_age == TO - 1) begin m_busy = 0; m_fin = 1; m_err = 1; end
      else m_age++;
    end
  end

  task automatic cyc(input bit r, input bit id, input bit op, input bit dn, input bit fl,
                     input logic [31:0] pc = 32'h0);
    @(posedge clk); #1;
    rst = r; id_stall_req_i = id; ex_multi_op_i = op; multi_done_i = dn; flush_req_i = fl;
    flush_pc_i = pc;
    @(negedge clk);
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("lit_reset_stall", 32'(stall_o), 32'h0);
    check("lit_reset_cnt", stall_cnt_o, 32'h0);
    check("lit_reset_flush", 32'(flush_o), 32'h0);
    // load-use for a single cycle
    cyc(0, 1, 0, 0, 0);
    check("lit_loaduse", 32'(stall_o), 32'h07);
    cyc(0, 0, 0, 0, 0);
    check("lit_loaduse_off", 32'(stall_o), 32'h0);
    check("lit_cnt1", stall_cnt_o, 32'd1);
    // multi-cycle op, done at BUSY cycle 3
    cyc(0, 0, 1, 0, 0);
    check("lit_start", 32'(multi_start_o), 32'd1);
    check("lit_multi_stall", 32'(stall_o), 32'h0F);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, k == 3, 0);
      check("lit_busy_stall", 32'(stall_o), 32'h0F);
      check("lit_no_restart", 32'(multi_start_o), 32'd0);
    end
    cyc(0, 1, 1, 0, 0);
    check("lit_done_stall", 32'(stall_o), 32'h0);
    check("lit_done_nostart", 32'(multi_start_o), 32'd0);
    cyc(0, 0, 0, 0, 0);
    check("lit_cnt6", stall_cnt_o, 32'd6);
    // flush while BUSY, load-use concurrent
    cyc(0, 0, 1, 0, 0);
    cyc(0, 1, 1, 0, 0);
    check("lit_busy_id", 32'(stall_o), 32'h0F);
    cyc(0, 1, 1, 0, 1, 32'h00000180);
    check("lit_flush_cancel", 32'(multi_cancel_o), 32'd1);
    cyc(0, 1, 0, 0, 0);
    check("lit_flush_o", 32'(flush_o), 32'd1);
    check("lit_new_pc", new_pc_o, 32'h00000180);
    check("lit_flush_stall", 32'(stall_o), 32'h0);
    // back-to-back flushes in IDLE, start suppressed
    cyc(0, 0, 1, 0, 1, 32'hA0);
    check("lit_flush_nostart", 32'(multi_start_o), 32'd0);
    cyc(0, 0, 0, 0, 1, 32'hB4);
    check("lit_pc_a", new_pc_o, 32'hA0);
    cyc(0, 0, 0, 0, 0);
    check("lit_pc_b", new_pc_o, 32'hB4);
    // flush and done together: cancel, back to IDLE (not DONE)
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 1, 1, 32'h40);
    check("lit_fd_cancel", 32'(multi_cancel_o), 32'd1);
    cyc(0, 0, 1, 0, 0);
    check("lit_fd_restart", 32'(multi_start_o), 32'd1);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // watchdog
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 1, 0, 0);
      check("lit_wd_cancel", 32'(multi_cancel_o), 32'(k == 3));
    end
    cyc(0, 0, 1, 0, 0);
    check("lit_wd_err", 32'(timeout_err_o), 32'd1);
    check("lit_wd_done_stall", 32'(stall_o), 32'h0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 0);
    check("lit_err_sticky", 32'(timeout_err_o), 32'd1);
    // reset mid-BUSY
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 1, 32'h99);
    check("lit_rst_nocancel", 32'(multi_cancel_o), 32'd0);
    check("lit_rst_stall", 32'(stall_o), 32'h0);
    cyc(0, 0, 0, 0, 0);
    check("lit_post_rst_err", 32'(timeout_err_o), 32'd0);
    check("lit_post_rst_cnt", stall_cnt_o, 32'd0);
    check("lit_post_rst_flush", 32'(flush_o), 32'd0);
    check("lit_post_rst_pc", new_pc_o, 32'd0);
    check("lit_post_rst_cancel", 32'(multi_cancel_o), 32'd0);
    cyc(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
